urisc_port_tx: RTL and testbench
================================

# urisc_port_tx

Output-port serializer that sits directly downstream of the URISC core's 8-bit `out_port`. It watches the port for value changes and queues each new value in a small FIFO. It then transmits each queued byte as an 8N1 asynchronous serial frame on `tx`. This makes the core's output register visible off-chip without stalling the processor.

## Interface
Parameters:
- `CLK_DIV`, default 16: clock cycles per serial bit. Legal range is ≥2.
- `FIFO_DEPTH`, default 4: FIFO entries. Must be a power of 2 and ≥2.

Ports:
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `port_data` input 8: connected to the core `out_port`.
- `tx` output 1: serial line. It idles high.
- `busy` output 1: high while a frame is in progress.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: number of queued bytes, not counting the byte being sent.
- `overflow` output 1: sticky flag meaning a change was dropped because the FIFO was full.

## Operation
Change detector:
- Register `prev` resets to 8'hFF, which matches the core's reset value of r[15].
- On each edge where `port_data != prev`, `prev` takes `port_data` and an enqueue request is raised.
- Equal values never enqueue. A value that changes and then returns to an earlier value enqueues twice.

FIFO:
- Circular buffer with a read pointer, a write pointer and a count. Pointers wrap modulo FIFO_DEPTH.
- Enqueue while `fifo_count == FIFO_DEPTH`, with no pop on the same edge: the byte is dropped, `overflow` is set, and `prev` still updates.
- Enqueue and pop on the same edge: both are performed and the count is unchanged. This is accepted even when the FIFO is full.
- Enqueue and pop when `fifo_count == 0`: the new byte is written to the FIFO. The pop is not serviced from the incoming byte.
- `overflow` is cleared only by reset.

Transmit FSM, with states IDLE, START, DATA and STOP:
- IDLE: `tx`=1, `busy`=0. If `fifo_count > 0`, pop into an 8-bit shift register, clear the baud counter and bit index, and go to START.
- START: `tx`=0 for CLK_DIV cycles, then go to DATA.
- DATA: `tx`=shift[0], LSB first. Every CLK_DIV cycles, shift right and increment the bit index. After bit 7 completes, go to STOP.
- STOP: `tx`=1 for CLK_DIV cycles. At the end of STOP:
  - If the FIFO is non-empty, pop and go straight to START, with no idle gap.
  - Otherwise go to IDLE.
- `busy` is 1 in START, DATA and STOP.
- Baud counter: counts 0..CLK_DIV-1 and wraps to 0 on each bit boundary. Width is $clog2(CLK_DIV).
- `tx` is driven from a register, so it has no glitches.
- The state encoding includes a default branch that returns to IDLE with `tx`=1.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0, state IDLE, `prev`=8'hFF, FIFO pointers=0.
- Enqueue latency:
  - `port_data` changes before edge E0.
  - At E0 the byte is written and `fifo_count` increments.
  - At E1, if IDLE, the byte is popped and `tx` falls.
- Frame length is exactly 10×CLK_DIV cycles, from the `tx` fall to the end of STOP.
- Back-to-back frames: the next start bit begins on the edge that ends the previous STOP.
- Sustained throughput limit: one change per 10×CLK_DIV cycles. The core can change `out_port` every 3 cycles, so bursts longer than FIFO_DEPTH+1 changes overflow.
- Reset asserted mid-frame:
  - `tx` goes to 1 immediately (asynchronously).
  - The FIFO is emptied, `busy` drops, and `overflow` clears.
  - No partial-frame continuation after release.
- After reset release, the first edge behaves as a normal edge. A `port_data` value other than FF is enqueued at that edge.

## Test plan
- Single byte: CLK_DIV=4, `port_data` changes FF→5A.
  - Expect `tx` = 0 (4 cycles), then 0,1,0,1,1,0,1,0 (4 cycles each), then 1 (4 cycles).
  - `busy` is high for 40 cycles and `fifo_count` returns to 0.
- No change: `port_data` held at FF for 500 cycles after reset.
  - `tx` stays 1, `busy`=0, `fifo_count`=0.
- Burst: change to 01,02,03 on three consecutive edges (CLK_DIV=4, depth 4).
  - Frames for 01, 02 and 03 are sent back-to-back, 120 cycles total, with no idle cycle between frames.
  - `overflow`=0.
- Overflow: with a frame in progress, issue 6 distinct changes on consecutive edges (depth 4).
  - The first 4 are queued and the remaining 2 are dropped.
  - `overflow`=1 and stays 1 until reset.
  - Exactly 5 frames are observed in total: the one in progress plus 4 queued.
- Reset mid-frame: assert `reset` low during bit 3 of frame A5.
  - `tx`=1 asynchronously, and `fifo_count`, `busy` and `overflow` are all 0.
  - After release, with `port_data`=A5, one new full A5 frame starts 1 cycle after the first edge.
- Full + simultaneous pop: FIFO full, and an enqueue lands on the STOP-end edge.
  - The byte is accepted, `fifo_count` stays at FIFO_DEPTH, and `overflow` stays 0.

Source files
------------

// File: rtl/urisc_port_tx.sv
// urisc_port_tx: watches the core out_port for changes, queues them in a FIFO
// and replays each queued byte as an 8N1 serial frame on tx.
module urisc_port_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    port_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [7:0]      prev_q;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            enq, full, empty, wr, pop, baud_end;

    assign enq      = port_data != prev_q;
    assign full     = count_q == CW'(FIFO_DEPTH);
    assign empty    = count_q == '0;
    // A pop on the same edge frees a slot, so a full FIFO still accepts the byte
    assign wr       = enq && (!full || pop);
    assign count_d  = count_q + CW'(wr) - CW'(pop);
    assign baud_end = baud_q == BW'(CLK_DIV - 1);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        baud_d  = (state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
        case (state_q)
            IDLE: begin
                pop     = !empty;
                state_d = empty ? IDLE : START;
                tx_d    = empty;
            end
            START: begin
                state_d = baud_end ? DATA : START;
                tx_d    = baud_end ? shift_q[0] : 1'b0;
            end
            DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
                    tx_d    = (bit_q == 3'd7) ? 1'b1 : shift_q[1];
                end
            end
            STOP: begin
                if (baud_end) begin
                    pop     = !empty;
                    state_d = empty ? IDLE : START;
                    tx_d    = empty;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            bit_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            prev_q     <= 8'hFF;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            prev_q     <= port_data;
            rd_ptr_q   <= rd_ptr_q + AW'(pop);
            wr_ptr_q   <= wr_ptr_q + AW'(wr);
            count_q    <= count_d;
            overflow_q <= overflow_q | (enq & ~wr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= port_data;
    end

    assign tx         = tx_q;
    assign busy       = state_q != IDLE;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_urisc_port_tx.sv
// tb_urisc_port_tx: table-driven, directed and random checks of urisc_port_tx
// against a cycle-level queue/timeline model and a serial-line receiver.
module tb_urisc_port_tx;
    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] port_data = 8'hFF;
    logic       tx, busy, overflow;
    logic [2:0] fifo_count;

    urisc_port_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .port_data(port_data), .tx(tx),
        .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int busy_cyc = 0;

    // Reference model: byte queue plus the timeline of the frame on the wire
    logic [7:0] prev_m, fbyte;
    logic [7:0] q_m[$];
    logic [7:0] exp_rx[$];
    logic [7:0] rx_q[$];
    int         kk = 0, free_at = 0, fstart = 0;
    logic       fvalid = 1'b0;
    logic       e_tx = 1'b1, e_busy = 1'b0, e_ovf = 1'b0;
    int         e_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h edge=%0d", name, act, exp, kk);
        end
    endtask

    task automatic model_reset();
        prev_m = 8'hFF;
        q_m.delete();
        exp_rx.delete();
        rx_q.delete();
        free_at = 0;
        fvalid = 1'b0;
        e_ovf = 1'b0;
        e_tx = 1'b1;
        e_busy = 1'b0;
        e_cnt = 0;
    endtask

    task automatic model_edge(input logic [7:0] pd);
        logic enq;
        int j;
        kk++;
        enq = pd != prev_m;
        prev_m = pd;
        if (q_m.size() > 0 && kk >= free_at) begin
            fbyte = q_m.pop_front();
            exp_rx.push_back(fbyte);
            fstart = kk;
            fvalid = 1'b1;
            free_at = kk + 10 * D;
        end
        if (enq) begin
            if (q_m.size() < DEPTH) q_m.push_back(pd);
            else e_ovf = 1'b1;
        end
        j = (kk - fstart) / D;
        e_busy = fvalid && (kk - fstart) < 10 * D;
        e_tx = !e_busy ? 1'b1 : (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : fbyte[j-1];
        e_cnt = q_m.size();
    endtask

    task automatic step(input logic [7:0] pd);
        port_data = pd;
        @(posedge clk);
        model_edge(pd);
        #1;
        chk("tx", tx, e_tx);
        chk("busy", busy, e_busy);
        chk("fifo_count", fifo_count, e_cnt);
        chk("overflow", overflow, e_ovf);
        if (busy) busy_cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        repeat (2 * D + 2) begin
            @(posedge clk);
            #1;
            chk("rst_hold_tx", tx, 1);
        end
        reset = 1'b1;
        model_reset();
        busy_cyc = 0;
    endtask

    task automatic run_idle(input logic [7:0] pd);
        int n = 0;
        while ((e_busy || q_m.size() != 0) && n < 3000) begin
            step(pd);
            n++;
        end
        chk("drain_timeout", (n >= 3000) ? 1 : 0, 0);
        repeat (2 * D) step(pd);
        chk("rx_count", rx_q.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++)
            chk("rx_byte", rx_q[i], exp_rx[i]);
    endtask

    // Serial receiver: samples the first cycle of every bit, abandons on reset
    logic [7:0] rx_b;
    logic       rx_ok;
    always @(negedge clk) begin
        if (reset && !tx) begin
            rx_ok = 1'b1;
            for (int i = 0; i < 9; i++) begin
                repeat (D) @(negedge clk);
                if (!reset) begin
                    rx_ok = 1'b0;
                    break;
                end
                if (i < 8) rx_b[i] = tx;
                else begin
                    checks++;
                    if (!tx) begin
                        errors++;
                        rx_ok = 1'b0;
                        $display("FAIL stop_bit actual=0 expected=1 edge=%0d", kk);
                    end
                end
            end
            if (rx_ok) rx_q.push_back(rx_b);
        end
    end

    typedef struct packed {
        int              n;
        logic [6:0][7:0] seq;
        int              hold;
        int              nexp;
        logic [6:0][7:0] exp_b;
        int              exp_busy;
        logic            exp_ovf;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pd_cur;
        tbl[0] = '{1, 56'h5A, 0, 1, 56'h5A, 40, 1'b0};
        tbl[1] = '{0, 56'h0, 500, 0, 56'h0, 0, 1'b0};
        tbl[2] = '{3, 56'h030201, 0, 3, 56'h030201, 120, 1'b0};
        tbl[3] = '{7, 56'h26252423222111, 0, 5, 56'h2423222111, 200, 1'b1};
        tbl[4] = '{3, 56'h102010, 0, 3, 56'h102010, 120, 1'b0};
        #2;
        for (int t = 0; t < 5; t++) begin
            do_reset();
            pd_cur = 8'hFF;
            for (int i = 0; i < tbl[t].n; i++) begin
                pd_cur = tbl[t].seq[i];
                step(pd_cur);
            end
            repeat (tbl[t].hold) step(pd_cur);
            run_idle(pd_cur);
            chk("tbl_frames", rx_q.size(), tbl[t].nexp);
            for (int i = 0; i < tbl[t].nexp && i < rx_q.size(); i++)
                chk("tbl_byte", rx_q[i], tbl[t].exp_b[i]);
            chk("tbl_busy_cycles", busy_cyc, tbl[t].exp_busy);
            chk("tbl_overflow", overflow, tbl[t].exp_ovf);
        end

        // Reset during bit 3 of an A5 frame with a full FIFO and overflow set
        do_reset();
        step(8'hA5);
        for (int i = 1; i <= 6; i++) step(8'(i));
        while (kk - fstart < 4 * D + 1) step(8'h06);
        chk("pre_rst_ovf", overflow, 1);
        chk("pre_rst_cnt", fifo_count, DEPTH);
        port_data = 8'hA5;
        do_reset();
        step(8'hA5);
        chk("restart_e0_tx", tx, 1);
        chk("restart_e0_cnt", fifo_count, 1);
        step(8'hA5);
        chk("restart_e1_tx", tx, 0);
        chk("restart_e1_busy", busy, 1);
        run_idle(8'hA5);
        chk("restart_frames", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("restart_byte", rx_q[0], 8'hA5);

        // Full FIFO with an enqueue landing on the STOP-end edge
        do_reset();
        for (int i = 0; i < 5; i++) step(8'h31 + 8'(i));
        while (kk + 1 - fstart != 10 * D) step(8'h35);
        chk("full_before", fifo_count, DEPTH);
        step(8'h36);
        chk("full_pop_cnt", fifo_count, DEPTH);
        chk("full_pop_ovf", overflow, 0);
        chk("full_pop_tx", tx, 0);
        run_idle(8'h36);
        chk("full_pop_frames", rx_q.size(), 6);

        // Random change patterns at several densities
        do_reset();
        pd_cur = 8'hFF;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, b * 15 + 2) == 0) pd_cur = 8'($urandom);
                step(pd_cur);
            end
        run_idle(pd_cur);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
